// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART frame scheduler.
// Holds the FSM state enum, frame defaults and frame byte builder.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic ch_t;

    localparam logic [7:0] HEADER_DEF    = 8'hA5;
    localparam int         FRAME_LEN_DEF = 4;

    // Byte idx of a frame: header, {ch, sample hi}, sample lo, xor check.
    function automatic logic [7:0] frame_byte(
        input logic [7:0]  hdr,
        input ch_t         ch,
        input logic [11:0] s,
        input logic [1:0]  idx
    );
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] res;
        b1 = {3'b000, ch, s[11:8]};
        b2 = s[7:0];
        unique case (idx)
            2'd0:    res = hdr;
            2'd1:    res = b1;
            2'd2:    res = b2;
            default: res = hdr ^ b1 ^ b2;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-channel round-robin arbiter.
// On contention the channel not granted last wins; a lone request always wins.
module rr_arbiter2
    import uart_sched_pkg::*;
(
    input  logic [1:0] req,
    input  ch_t        last,
    output logic [1:0] grant
);

    // One-hot grant from request pair and last-granted channel
    always_comb begin
        if (req == 2'b11)
            grant = last ? 2'b01 : 2'b10;
        else
            grant = req;
    end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Picks one pending ADC channel, frames its sample into four
// bytes and streams them to a UART transmitter with backpressure.
module uart_frame_scheduler
    import uart_sched_pkg::*;
#(
    parameter logic [7:0] HEADER    = HEADER_DEF,
    parameter int         FRAME_LEN = FRAME_LEN_DEF
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    input  logic [11:0] req_data0,
    input  logic [11:0] req_data1,
    output logic [1:0]  req_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_idx;
    logic [1:0]  w_idx_nxt;
    logic [11:0] r_sample;
    ch_t         r_ch;
    ch_t         r_last;
    logic [1:0]  r_req_ready;
    logic [1:0]  w_req_ready_nxt;
    logic        r_tx_valid;
    logic        w_tx_valid_nxt;
    logic [7:0]  r_tx_data;
    logic [7:0]  w_tx_data_nxt;
    logic        r_busy;
    logic        w_busy_nxt;
    logic [15:0] r_frame_count;
    logic [15:0] w_frame_count_nxt;
    logic [1:0]  w_grant;
    logic        w_start;
    logic        w_xfer;

    rr_arbiter2 u_arb (
        .req   (req_valid),
        .last  (r_last),
        .grant (w_grant)
    );

    assign w_start = (r_state == IDLE) && (req_valid != 2'b00);
    assign w_xfer  = (r_state == SEND) && r_tx_valid && tx_ready;

    // State register; reset aborts any frame in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_start) w_state_nxt = SEND;
            SEND:    if (w_xfer && r_idx == LAST_IDX) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and byte index
    always_comb begin
        w_req_ready_nxt   = 2'b00;
        w_tx_valid_nxt    = r_tx_valid;
        w_tx_data_nxt     = r_tx_data;
        w_idx_nxt         = r_idx;
        w_frame_count_nxt = r_frame_count;
        w_busy_nxt        = (w_state_nxt != IDLE);
        unique case (r_state)
            IDLE: begin
                w_tx_valid_nxt = 1'b0;
                if (w_start) begin
                    w_req_ready_nxt = w_grant;
                    w_tx_valid_nxt  = 1'b1;
                    w_tx_data_nxt   = HEADER;
                    w_idx_nxt       = 2'd0;
                end
            end
            SEND: begin
                if (w_xfer) begin
                    if (r_idx == LAST_IDX) begin
                        w_tx_valid_nxt = 1'b0;
                        w_tx_data_nxt  = 8'h00;
                        w_idx_nxt      = 2'd0;
                    end else begin
                        w_idx_nxt     = r_idx + 2'd1;
                        w_tx_data_nxt = frame_byte(HEADER, r_ch,
                                                   r_sample,
                                                   r_idx + 2'd1);
                    end
                end
            end
            DONE: begin
                w_tx_valid_nxt    = 1'b0;
                w_frame_count_nxt = r_frame_count + 16'd1;
            end
            default: begin
                w_tx_valid_nxt = 1'b0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx         <= 2'd0;
            r_req_ready   <= 2'b00;
            r_tx_valid    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_busy        <= 1'b0;
            r_frame_count <= 16'h0000;
        end else begin
            r_idx         <= w_idx_nxt;
            r_req_ready   <= w_req_ready_nxt;
            r_tx_valid    <= w_tx_valid_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_busy        <= w_busy_nxt;
            r_frame_count <= w_frame_count_nxt;
        end
    end

    // Sample capture at grant; last grant starts at ch1 so ch0 wins first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sample <= 12'h000;
            r_ch     <= 1'b0;
            r_last   <= 1'b1;
        end else if (w_start) begin
            r_sample <= w_grant[1] ? req_data1 : req_data0;
            r_ch     <= w_grant[1];
            r_last   <= w_grant[1];
        end
    end

    assign req_ready   = r_req_ready;
    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign busy        = r_busy;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler: single, contention,
// backpressure, mid-frame reset, counter wrap and data-hold cases.
module tb_uart_frame_scheduler;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [11:0] req_data0;
    logic [11:0] req_data1;
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [15:0] frame_count;

    int errors;
    int checks;
    int pulses0;
    int pulses1;
    int both_seen;
    int snap0;
    int snap1;
    logic [31:0] f;

    uart_frame_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor sampled on the falling edge
    always @(negedge clk) begin
        if (req_ready[0]) pulses0 <= pulses0 + 1;
        if (req_ready[1]) pulses1 <= pulses1 + 1;
        if (req_ready == 2'b11) both_seen <= both_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Gather four transferred bytes, advancing one falling edge per look
    task automatic collect(output logic [31:0] fr);
        int n;
        n  = 0;
        fr = 32'h0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            if (tx_valid && tx_ready) begin
                fr = {fr[23:0], tx_data};
                n++;
            end
            @(negedge clk);
        end
        check("frame_bytes_seen", 32'(n), 32'd4);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        pulses0   = 0;
        pulses1   = 0;
        both_seen = 0;
        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_data0 = 12'h000;
        req_data1 = 12'h000;
        tx_ready  = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single ch0 request; sample changes after capture
        snap0     = pulses0;
        req_valid = 2'b01;
        req_data0 = 12'h3C7;
        @(negedge clk);
        check("single_req_ready", 32'(req_ready), 32'h1);
        check("single_busy", 32'(busy), 32'd1);
        req_valid = 2'b00;
        req_data0 = 12'hFFF;
        collect(f);
        check("single_frame", f, 32'hA503C761);
        wait_idle();
        check("single_count", 32'(frame_count), 32'd1);
        check("single_pulses0", 32'(pulses0 - snap0), 32'd1);

        // Contention from fresh reset: ch0, ch1, ch0
        reset_n = 1'b0;
        @(negedge clk);
        check("rst2_count", 32'(frame_count), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        snap0     = pulses0;
        snap1     = pulses1;
        req_data0 = 12'h001;
        req_data1 = 12'h802;
        req_valid = 2'b11;
        collect(f);
        check("cont_frame0", f, 32'hA50001A4);
        collect(f);
        check("cont_frame1", f, 32'hA51802BF);
        collect(f);
        check("cont_frame2", f, 32'hA50001A4);
        req_valid = 2'b00;
        wait_idle();
        check("cont_count", 32'(frame_count), 32'd3);
        check("cont_pulses0", 32'(pulses0 - snap0), 32'd2);
        check("cont_pulses1", 32'(pulses1 - snap1), 32'd1);
        check("cont_both_ready", 32'(both_seen), 32'd0);

        // Backpressure on byte2 for five cycles
        req_data1 = 12'h5A3;
        req_valid = 2'b10;
        @(negedge clk);
        check("bp_req_ready", 32'(req_ready), 32'h2);
        check("bp_byte0", 32'({tx_valid, tx_data}), 32'h1A5);
        req_valid = 2'b00;
        @(negedge clk);
        check("bp_byte1", 32'({tx_valid, tx_data}), 32'h115);
        @(negedge clk);
        check("bp_byte2", 32'({tx_valid, tx_data}), 32'h1A3);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", 32'({tx_valid, tx_data}), 32'h1A3);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        check("bp_byte3", 32'({tx_valid, tx_data}), 32'h113);
        @(negedge clk);
        check("bp_valid_drop", 32'(tx_valid), 32'd0);
        wait_idle();
        check("bp_count", 32'(frame_count), 32'd4);

        // Reset after byte1 aborts the frame
        req_data0 = 12'h3C7;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        check("mr_byte1", 32'({tx_valid, tx_data}), 32'h103);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mr_tx_valid", 32'(tx_valid), 32'd0);
        check("mr_count", 32'(frame_count), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("mr_no_resume", 32'(tx_valid), 32'd0);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        collect(f);
        check("mr_new_frame", f, 32'hA503C761);
        wait_idle();
        check("mr_count_after", 32'(frame_count), 32'd1);

        // Counter wrap from 16'hFFFF
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        force dut.r_frame_count = 16'hFFFF;
        #1;
        release dut.r_frame_count;
        check("wrap_preload", 32'(frame_count), 32'hFFFF);
        collect(f);
        check("wrap_frame", f, 32'hA503C761);
        wait_idle();
        check("wrap_count", 32'(frame_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
